// File: rtl/fsm_calculator_alu_pkg.sv
// Shared types and key codes for the keypad calculator (package calc_pkg).
// The optional divider is enabled with the CALC_DIV_EN macro.
package calc_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_OPERAND_A = 3'd1,
        ST_OPERATOR  = 3'd2,
        ST_OPERAND_B = 3'd3,
        ST_RESULT    = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_DIV  = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        KEY_NONE  = 3'd0,
        KEY_DIGIT = 3'd1,
        KEY_OP    = 3'd2,
        KEY_EQUAL = 3'd3,
        KEY_CLEAR = 3'd4
    } key_e;

    // Scanned code layout: {2'b00, col[1:0], 1'b0, valid, row[1:0]}
    localparam logic [7:0] CODE_CLEAR = 8'h04;
    localparam logic [7:0] CODE_EQUAL = 8'h24;
    localparam logic [7:0] CODE_DIV   = 8'h34;
    localparam logic [7:0] CODE_MUL   = 8'h35;
    localparam logic [7:0] CODE_SUB   = 8'h36;
    localparam logic [7:0] CODE_ADD   = 8'h37;

    function automatic logic code_valid(input logic [7:0] code);
        return (code[7:6] == 2'b00) && !code[3] && code[2];
    endfunction

    function automatic logic [DATA_W-1:0] acc_digit(input logic [DATA_W-1:0] v,
                                                    input logic [3:0]        d);
        return v * 16'd10 + {12'd0, d};
    endfunction

endpackage

// File: rtl/fsm_calculator_alu_alu.sv
// Combinational 16-bit ALU for the calculator; divider only with CALC_DIV_EN.
module calc_alu
    import calc_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic [2:0]  op_i,
    output logic [15:0] y_o
);

    always_comb begin
        y_o = a_i;
        case (op_i)
            OP_ADD: y_o = a_i + b_i;
            OP_SUB: y_o = a_i - b_i;
            OP_MUL: y_o = a_i * b_i;
`ifdef CALC_DIV_EN
            // Divide by zero saturates to all ones rather than trapping
            OP_DIV: y_o = (b_i == 16'd0) ? 16'hFFFF : a_i / b_i;
`endif
            default: y_o = a_i;
        endcase
    end

endmodule

// File: rtl/fsm_calculator_alu.sv
// Keypad calculator top: key decode, press detection, entry FSM, output registers.
// Define CALC_DIV_EN to accept the DIV key; otherwise it is ignored.
module fsm_calculator_alu
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  button,
    output logic        clear,
    output logic [3:0]  button_num,
    output logic [2:0]  button_op,
    output logic        equal,
    output logic [15:0] result_temp,
    output logic [15:0] result
);

    state_e      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] res_q, res_d;
    logic [15:0] rt_q, rt_d;
    logic [3:0]  num_q, num_d;
    logic [2:0]  op_q, op_d;
    logic        clear_q, clear_d;
    logic        equal_q, equal_d;
    logic [7:0]  prev_q;

    key_e        key_kind;
    logic [3:0]  key_digit;
    logic [2:0]  key_op;
    logic        press;
    logic [15:0] alu_y;

    calc_alu u_alu (
        .a_i  (a_q),
        .b_i  (b_q),
        .op_i (op_q),
        .y_o  (alu_y)
    );

    // A held key is one press; only a change to a valid code counts
    assign press = code_valid(button) && (button != prev_q);

    always_comb begin
        key_kind  = KEY_NONE;
        key_digit = 4'd0;
        key_op    = OP_NONE;
        case ({button[5:4], button[1:0]})
            4'b00_00: key_kind = KEY_CLEAR;
            4'b00_01: begin key_kind = KEY_DIGIT; key_digit = 4'd1; end
            4'b00_10: begin key_kind = KEY_DIGIT; key_digit = 4'd4; end
            4'b00_11: begin key_kind = KEY_DIGIT; key_digit = 4'd7; end
            4'b01_00: begin key_kind = KEY_DIGIT; key_digit = 4'd0; end
            4'b01_01: begin key_kind = KEY_DIGIT; key_digit = 4'd2; end
            4'b01_10: begin key_kind = KEY_DIGIT; key_digit = 4'd5; end
            4'b01_11: begin key_kind = KEY_DIGIT; key_digit = 4'd8; end
            4'b10_00: key_kind = KEY_EQUAL;
            4'b10_01: begin key_kind = KEY_DIGIT; key_digit = 4'd3; end
            4'b10_10: begin key_kind = KEY_DIGIT; key_digit = 4'd6; end
            4'b10_11: begin key_kind = KEY_DIGIT; key_digit = 4'd9; end
`ifdef CALC_DIV_EN
            4'b11_00: begin key_kind = KEY_OP; key_op = OP_DIV; end
`else
            4'b11_00: key_kind = KEY_NONE;
`endif
            4'b11_01: begin key_kind = KEY_OP; key_op = OP_MUL; end
            4'b11_10: begin key_kind = KEY_OP; key_op = OP_SUB; end
            4'b11_11: begin key_kind = KEY_OP; key_op = OP_ADD; end
            default:  key_kind = KEY_NONE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        num_d   = num_q;
        op_d    = op_q;
        clear_d = 1'b0;
        equal_d = 1'b0;
        if (press) begin
            case (key_kind)
                KEY_CLEAR: begin
                    state_d = ST_IDLE;
                    a_d     = 16'd0;
                    b_d     = 16'd0;
                    res_d   = 16'd0;
                    num_d   = 4'd0;
                    op_d    = OP_NONE;
                    clear_d = 1'b1;
                end
                KEY_DIGIT: begin
                    num_d = key_digit;
                    case (state_q)
                        ST_OPERAND_A: a_d = acc_digit(a_q, key_digit);
                        ST_OPERATOR: begin
                            b_d     = {12'd0, key_digit};
                            state_d = ST_OPERAND_B;
                        end
                        ST_OPERAND_B: b_d = acc_digit(b_q, key_digit);
                        default: begin
                            a_d     = {12'd0, key_digit};
                            state_d = ST_OPERAND_A;
                        end
                    endcase
                end
                KEY_OP: begin
                    // Left-to-right evaluation: fold the pending op before storing the new one
                    case (state_q)
                        ST_IDLE:      a_d = 16'd0;
                        ST_OPERAND_B: a_d = alu_y;
                        ST_RESULT:    a_d = res_q;
                        default:      a_d = a_q;
                    endcase
                    op_d    = key_op;
                    state_d = ST_OPERATOR;
                end
                KEY_EQUAL: begin
                    equal_d = 1'b1;
                    case (state_q)
                        ST_OPERAND_A, ST_OPERATOR: begin
                            res_d   = a_q;
                            op_d    = OP_NONE;
                            state_d = ST_RESULT;
                        end
                        ST_OPERAND_B: begin
                            a_d     = alu_y;
                            res_d   = alu_y;
                            op_d    = OP_NONE;
                            state_d = ST_RESULT;
                        end
                        default: state_d = state_q;
                    endcase
                end
                default: state_d = state_q;
            endcase
        end
        rt_d = (state_d == ST_OPERAND_B) ? b_d : a_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            res_q   <= 16'd0;
            rt_q    <= 16'd0;
            num_q   <= 4'd0;
            op_q    <= OP_NONE;
            clear_q <= 1'b0;
            equal_q <= 1'b0;
            prev_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            rt_q    <= rt_d;
            num_q   <= num_d;
            op_q    <= op_d;
            clear_q <= clear_d;
            equal_q <= equal_d;
            prev_q  <= button;
        end
    end

    assign clear       = clear_q;
    assign equal       = equal_q;
    assign button_num  = num_q;
    assign button_op   = op_q;
    assign result_temp = rt_q;
    assign result      = res_q;

endmodule

// File: tb/tb_fsm_calculator_alu.sv
// Scoreboard bench for fsm_calculator_alu; expectations follow CALC_DIV_EN.
module tb_fsm_calculator_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  button;
    logic        clear;
    logic [3:0]  button_num;
    logic [2:0]  button_op;
    logic        equal;
    logic [15:0] result_temp;
    logic [15:0] result;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic        is_clear;
        logic [15:0] res;
        logic [15:0] rt;
    } exp_t;

    exp_t sb[$];

    localparam logic [7:0] K_CLR = 8'h04, K_EQ = 8'h24, K_DIV = 8'h34, K_MUL = 8'h35;
    localparam logic [7:0] K_SUB = 8'h36, K_ADD = 8'h37;
    localparam logic [7:0] K0 = 8'h14, K1 = 8'h05, K2 = 8'h15, K3 = 8'h25, K4 = 8'h06;
    localparam logic [7:0] K5 = 8'h16, K6 = 8'h26, K7 = 8'h07, K8 = 8'h17, K9 = 8'h27;

    fsm_calculator_alu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .button      (button),
        .clear       (clear),
        .button_num  (button_num),
        .button_op   (button_op),
        .equal       (equal),
        .result_temp (result_temp),
        .result      (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic key(input logic [7:0] c, input int n = 1);
        button = c;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic gap();
        button = 8'h00;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_eq(input logic [15:0] r);
        exp_t e;
        e.is_clear = 1'b0;
        e.res      = r;
        e.rt       = r;
        sb.push_back(e);
    endtask

    task automatic exp_clr();
        exp_t e;
        e.is_clear = 1'b1;
        e.res      = 16'd0;
        e.rt       = 16'd0;
        sb.push_back(e);
    endtask

    // Monitor: every clear/equal pulse consumes one expected response
    logic eq_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (equal) chk("equal_one_cycle", {15'd0, eq_prev}, 16'd0);
            if (equal || clear) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {15'd0, clear, 15'd0}, 16'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pulse_kind", {15'd0, clear}, {15'd0, e.is_clear});
                    chk("result", result, e.res);
                    chk("result_temp", result_temp, e.rt);
                    chk("button_op", {13'd0, button_op}, 16'd0);
                    if (e.is_clear) chk("button_num", {12'd0, button_num}, 16'd0);
                end
            end
            eq_prev <= equal;
        end else begin
            eq_prev <= 1'b0;
        end
    end

    initial begin
        rst_n  = 1'b0;
        button = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset in the middle of an entry
        key(K5); key(K_ADD);
        chk("pre_reset_rt", result_temp, 16'd5);
        #2 rst_n = 1'b0;
        button = 8'h00;
        #1;
        chk("rst_result", result, 16'd0);
        chk("rst_result_temp", result_temp, 16'd0);
        chk("rst_button_op", {13'd0, button_op}, 16'd0);
        chk("rst_button_num", {12'd0, button_num}, 16'd0);
        chk("rst_pulses", {14'd0, clear, equal}, 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 5 + 3 = 8, Clear, Equal in IDLE
        key(K5); key(K_ADD); key(K3);
        exp_eq(16'd8); key(K_EQ);
        exp_clr(); key(K_CLR);
        exp_eq(16'd0); key(K_EQ);

        // 5 - 3 + 2 = 4
        exp_clr(); key(K_CLR);
        key(K5); key(K_SUB); key(K3); key(K_ADD);
        chk("chain_rt", result_temp, 16'd2);
        chk("chain_op", {13'd0, button_op}, 16'd1);
        key(K2);
        exp_eq(16'd4); key(K_EQ);

        // 6 / 3 = then * 8 =
        exp_clr(); key(K_CLR);
        key(K6); key(K_DIV);
`ifdef CALC_DIV_EN
        chk("div_op", {13'd0, button_op}, 16'd4);
        key(K3); exp_eq(16'd2); key(K_EQ);
        key(K_MUL); key(K8); exp_eq(16'd16); key(K_EQ);
`else
        chk("div_ignored_op", {13'd0, button_op}, 16'd0);
        key(K3); exp_eq(16'd63); key(K_EQ);
        key(K_MUL); key(K8); exp_eq(16'd504); key(K_EQ);
`endif

        // 12 + 34 = 46, then 7 held three cycles
        exp_clr(); key(K_CLR);
        key(K1); key(K2); key(K_ADD); key(K3); key(K4);
        exp_eq(16'd46); key(K_EQ);
        key(K7, 3);
        chk("held_digit_num", {12'd0, button_num}, 16'd7);
        exp_eq(16'd7); key(K_EQ);

        // 9 / 0 =
        exp_clr(); key(K_CLR);
        key(K9); key(K_DIV); key(K0);
`ifdef CALC_DIV_EN
        exp_eq(16'hFFFF);
`else
        exp_eq(16'd90);
`endif
        key(K_EQ);

        // 3 - 5 = wraps
        exp_clr(); key(K_CLR);
        key(K3); key(K_SUB); key(K5);
        exp_eq(16'hFFFE); key(K_EQ);

        // 255 * 255 = keeps low 16 bits
        exp_clr(); key(K_CLR);
        key(K2); key(K5); gap(); key(K5); key(K_MUL);
        key(K2); key(K5); gap(); key(K5);
        exp_eq(16'hFE01); key(K_EQ);

        // Equal straight after an operator, and operator replacement
        exp_clr(); key(K_CLR);
        key(K4); key(K_ADD);
        exp_eq(16'd4); key(K_EQ);
        exp_clr(); key(K_CLR);
        key(K9); key(K_ADD); key(K_SUB); key(K2);
        exp_eq(16'd7); key(K_EQ);
        gap();

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_calculator_alu.md
# fsm_calculator_alu

Keypad-driven four-function integer calculator: decodes an 8-bit scanned-keypad code, tracks operand/operator entry with a state machine, and evaluates left-to-right with a 16-bit ALU. Sits between the keypad scanner and the display driver; all outputs are registered.

## Interface
- No parameters; widths fixed (DATA_W = 16).
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `button` in 8: keypad code; [5:4] keypad column, [2] key-valid, [1:0] keypad row; [7:6], [3] must be 0.
- `clear` out 1: one-cycle pulse, Clear key accepted.
- `button_num` out 4: last accepted digit, 0–9.
- `button_op` out 3: pending operator (0 NONE, 1 ADD, 2 SUB, 3 MUL, 4 DIV).
- `equal` out 1: one-cycle pulse, Equal key accepted.
- `result_temp` out 16: running accumulator A, or operand B while B is being entered.
- `result` out 16: last evaluated result; held until next Equal or Clear.

## Operation
- Key map (column,row): col0 = Clear,1,4,7; col1 = 0,2,5,8; col2 = Equal,3,6,9; col3 = DIV,MUL,SUB,ADD. Examples: 0x04 Clear, 0x16 digit 5, 0x24 Equal, 0x37 ADD.
- Valid code: [2]=1, [7:6]=0, [3]=0; anything else is no key.
- Press event: valid code AND button ≠ button_prev (registered previous code). Held key is one press; different codes on consecutive cycles are separate presses.
- States: IDLE, OPERAND_A, OPERATOR, OPERAND_B, RESULT.
- Clear (any state) → IDLE; A, B, result, button_num, button_op = 0; clear pulses.
- IDLE: digit d → A=d, OPERAND_A; op → A=0, store op, OPERATOR; Equal → stay, equal pulses.
- OPERAND_A: digit → A=A*10+d; op → store op, OPERATOR; Equal → result=A, RESULT.
- OPERATOR: digit → B=d, OPERAND_B; op → replace op; Equal → result=A, op=NONE, RESULT.
- OPERAND_B: digit → B=B*10+d; op → A=A op B, store new op, OPERATOR; Equal → A=A op B, result=A, op=NONE, RESULT.
- RESULT: digit → A=d (fresh), OPERAND_A; op → A=result, store op, OPERATOR; Equal → no change, equal pulses.
- Arithmetic unsigned mod 2^16: ADD/SUB wrap; MUL keeps low 16 bits; DIV is truncating quotient, divisor 0 → 0xFFFF. Digit accumulation wraps mod 2^16.
- Evaluation strictly left to right, no precedence.

## Timing
- Press sampled at rising edge k; all state/outputs updated at edge k (visible same cycle after edge); one press per cycle max.
- clear/equal high exactly one cycle per accepted press.
- Reset: all outputs 0, state IDLE, button_prev 0; reset mid-entry discards everything.
- ALU combinational within one cycle; no stalls, no handshake.

## Configuration
- `CALC_DIV_EN` defined: DIV key stored and evaluated as above.
- Undefined: DIV key ignored entirely (no state change, button_op unchanged); no divider synthesized.

## Structure
- Package `calc_pkg`: state enum, op enum (3-bit), key-code constants, DATA_W.
- Sub-module `calc_alu`: combinational (a, b, op) → 16-bit result, divider under `CALC_DIV_EN`.
- Top holds key decode, press detection, FSM, registers.

## Test plan
- Reset low mid-entry, release; then 5 + 3 = → result 8, equal pulses 1 cycle, then Clear → all outputs 0, state IDLE.
- 5 − 3 + 2 = (back-to-back one-cycle presses) → result_temp 2 after `+`, result 4.
- 6 / 3 = → result 2; then MUL, 8, = → result 16 (chaining from RESULT).
- Multi-digit 1,2 + 3,4 = → result 46; hold digit 7 for 3 cycles → single digit accepted.
- 9 / 0 = → result 0xFFFF; 3 − 5 = → 0xFFFE; 255 * 255 = → 0xFE01 (low 16 bits).
- Without `CALC_DIV_EN`: 6, DIV, 3, = → DIV ignored, result 63.
